vme_dev_sequencer: RTL and testbench

- Controller between the VME slave front end and up to NDEV internal device modules (status/version readout, config registers, etc.).
- Synchronises the asynchronous VME strobe and decodes the device field to a one-hot select.
- Presents a qualified strobe to exactly one device at a time, waits for the device acknowledge, then generates DTACK_B and the read-data mux.
- Generates a bus error on unmapped devices or acknowledge timeout, so a silent device never hangs the crate.

---
 rtl/vme_pkg.sv | 20 ++
 rtl/vme_strobe_sync.sv | 38 +++
 rtl/vme_dev_sequencer.sv | 141 ++++++++++++++
 tb/tb_vme_dev_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_pkg.sv
// Shared definitions for the VME device sequencer and related front-end blocks.
package vme_pkg;

  localparam int unsigned DEV_W       = 4;
  localparam int unsigned CMD_W       = 10;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned TMO_CYC_DEF = 255;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vme_strobe_sync.sv
// Two-flop synchroniser for the asynchronous VME strobe with rising-edge capture pulse.
module vme_strobe_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  output logic o_s_strb,
  output logic o_capture
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_valid;
  logic       r_armed;

  // Capture stays disarmed after reset until a genuinely sampled low is seen,
  // so a strobe held high through reset cannot look like a fresh edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_valid <= '0;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= i_strobe;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= {r_valid[0], 1'b1};
      if (r_valid[1] && !r_s2)
        r_armed <= 1'b1;
    end
  end

  assign o_s_strb  = r_s2;
  assign o_capture = r_armed & r_s2 & ~r_s3;

endmodule

// File: rtl/vme_dev_sequencer.sv
// Sequences one VME access onto a single internal device: select, strobe, wait ack,
// then DTACK or bus error (unmapped slot / ack timeout).
module vme_dev_sequencer
  import vme_pkg::*;
#(
  parameter int unsigned NDEV     = 8,
  parameter int unsigned TMO_CYC  = TMO_CYC_DEF,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                     FASTCLK,
  input  logic                     RST,
  input  logic                     STROBE,
  input  logic                     WRITE_B,
  input  logic [DEV_W-1:0]         DEV_SEL,
  input  logic [CMD_W-1:0]         CMD_IN,
  input  logic [DATA_W-1:0]        INDATA,
  input  logic [NDEV-1:0]          DEV_ACK,
  input  logic [DATA_W*NDEV-1:0]   DEV_RDATA,
  output logic [NDEV-1:0]          DEVICE,
  output logic [CMD_W-1:0]         COMMAND,
  output logic                     DEV_WRITE_B,
  output logic                     DEV_STROBE,
  output logic [DATA_W-1:0]        OUTDATA,
  output logic                     DTACK_B,
  output logic                     BERR_B,
  output logic [7:0]               ERR_CNT
);

  logic              w_s_strb;
  logic              w_capture;
  logic [2:0]        r_state;
  logic [DEV_W-1:0]  r_sel;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_wrb;
  logic [15:0]       r_tmo;
  logic [3:0]        r_hold;
  logic [DATA_W-1:0] r_outdata;
  logic [7:0]        r_err_cnt;

  logic [NDEV-1:0]   w_onehot;
  logic [DATA_W-1:0] w_rdata;
  logic              w_ack;
  logic              w_mapped;
  logic              w_tmo_hit;
  logic              w_unused;

  vme_strobe_sync u_sync (
    .i_clk     (FASTCLK),
    .i_rst     (RST),
    .i_strobe  (STROBE),
    .o_s_strb  (w_s_strb),
    .o_capture (w_capture)
  );

  always_comb begin
    w_onehot = '0;
    w_rdata  = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (32'(r_sel) == i) begin
        w_onehot[i] = 1'b1;
        w_rdata     = DEV_RDATA[DATA_W*i +: DATA_W];
      end
    end
  end

  assign w_ack     = |(DEV_ACK & w_onehot);
  assign w_mapped  = 32'(DEV_SEL) < NDEV;
  assign w_tmo_hit = (r_tmo == 16'(TMO_CYC));
  // Write data goes straight from the VME side to the devices; nothing here consumes it.
  assign w_unused  = ^INDATA;

  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_cmd     <= '0;
      r_wrb     <= 1'b1;
      r_tmo     <= '0;
      r_hold    <= '0;
      r_outdata <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_sel <= DEV_SEL;
            r_cmd <= CMD_IN;
            r_wrb <= WRITE_B;
            if (w_mapped) begin
              r_state <= ST_SELECT;
            end else begin
              r_state   <= ST_ERROR;
              r_hold    <= 4'(HOLD_CYC);
              r_err_cnt <= sat_inc8(r_err_cnt);
            end
          end
        end
        ST_SELECT: begin
          r_tmo   <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (r_tmo != '1)
            r_tmo <= r_tmo + 16'd1;
          // Ack is checked first so an ack landing on the timeout cycle still completes.
          if (w_ack) begin
            if (r_wrb)
              r_outdata <= w_rdata;
            r_hold  <= 4'(HOLD_CYC);
            r_state <= ST_ACK;
          end else if (w_tmo_hit) begin
            r_hold    <= 4'(HOLD_CYC);
            r_err_cnt <= sat_inc8(r_err_cnt);
            r_state   <= ST_ERROR;
          end else if (!w_s_strb) begin
            r_state <= ST_RELEASE;
          end
        end
        ST_ACK, ST_ERROR: begin
          if (r_hold != '0)
            r_hold <= r_hold - 4'd1;
          else if (!w_s_strb)
            r_state <= ST_RELEASE;
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign DEVICE      = (r_state == ST_SELECT || r_state == ST_ACCESS || r_state == ST_ACK)
                       ? w_onehot : '0;
  assign COMMAND     = r_cmd;
  assign DEV_WRITE_B = r_wrb;
  assign DEV_STROBE  = (r_state == ST_ACCESS) || (r_state == ST_ACK);
  assign OUTDATA     = r_outdata;
  assign DTACK_B     = (r_state != ST_ACK);
  assign BERR_B      = (r_state != ST_ERROR);
  assign ERR_CNT     = r_err_cnt;

endmodule

// File: tb/tb_vme_dev_sequencer.sv
// Scoreboard bench: a transaction-level model predicts each DTACK/BERR response.
module tb_vme_dev_sequencer;

  localparam int NDEV     = 8;
  localparam int TMO_CYC  = 255;
  localparam int HOLD_CYC = 2;
  localparam int NEVER    = 100000;

  logic              FASTCLK = 1'b0;
  logic              RST = 1'b1;
  logic              STROBE = 1'b0;
  logic              WRITE_B = 1'b1;
  logic [3:0]        DEV_SEL = '0;
  logic [9:0]        CMD_IN = '0;
  logic [15:0]       INDATA = '0;
  logic [NDEV-1:0]   DEV_ACK = '0;
  logic [16*NDEV-1:0] DEV_RDATA = '0;
  logic [NDEV-1:0]   DEVICE;
  logic [9:0]        COMMAND;
  logic              DEV_WRITE_B;
  logic              DEV_STROBE;
  logic [15:0]       OUTDATA;
  logic              DTACK_B;
  logic              BERR_B;
  logic [7:0]        ERR_CNT;

  vme_dev_sequencer #(.NDEV(NDEV), .TMO_CYC(TMO_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .FASTCLK(FASTCLK), .RST(RST), .STROBE(STROBE), .WRITE_B(WRITE_B),
    .DEV_SEL(DEV_SEL), .CMD_IN(CMD_IN), .INDATA(INDATA), .DEV_ACK(DEV_ACK),
    .DEV_RDATA(DEV_RDATA), .DEVICE(DEVICE), .COMMAND(COMMAND),
    .DEV_WRITE_B(DEV_WRITE_B), .DEV_STROBE(DEV_STROBE), .OUTDATA(OUTDATA),
    .DTACK_B(DTACK_B), .BERR_B(BERR_B), .ERR_CNT(ERR_CNT)
  );

  initial forever #5 FASTCLK = ~FASTCLK;

  typedef struct {
    bit              berr;
    logic [NDEV-1:0] dev;
    logic [9:0]      cmd;
    logic            wrb;
    logic [15:0]     out;
    logic [7:0]      err;
    int              lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  int          cur_sel = 0;
  int          cur_lat = NEVER;
  logic [15:0] m_out = '0;
  logic [7:0]  m_err = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Device model: acks the intended slot 'cur_lat' cycles into the strobed access.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge FASTCLK);
      if (RST || !DEV_STROBE) begin
        cnt = 0;
        DEV_ACK = '0;
      end else begin
        if (cnt == cur_lat && cur_sel < NDEV) DEV_ACK[cur_sel] = 1'b1;
        cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every DTACK/BERR assertion and checks bus rules.
  initial begin
    bit p_dt = 1, p_be = 1, p_ds = 0;
    int run = 0, rise_cyc = 0, cyc = 0;
    exp_t e;
    forever begin
      @(negedge FASTCLK);
      cyc++;
      if (mon_en && !RST) begin
        chk("ack_berr_exclusive", {DTACK_B, BERR_B} != 2'b00, 1);
        chk("device_onehot", $countones(DEVICE) <= 1, 1);
        if (!BERR_B) chk("berr_quiet", (DEVICE == '0) && !DEV_STROBE, 1);
        if (DEV_STROBE && !p_ds) rise_cyc = cyc;
        if ((!DTACK_B && p_dt) || (!BERR_B && p_be)) begin
          chk("resp_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_kind_berr", !BERR_B, e.berr);
            chk("resp_device", DEVICE, e.dev);
            chk("resp_command", COMMAND, e.cmd);
            chk("resp_write_b", DEV_WRITE_B, e.wrb);
            chk("resp_outdata", OUTDATA, e.out);
            chk("resp_err_cnt", ERR_CNT, e.err);
            if (e.lat >= 0) chk("resp_latency", cyc - rise_cyc, e.lat);
          end
        end
        if ((DTACK_B && !p_dt) || (BERR_B && !p_be)) begin
          chk("hold_length", run >= HOLD_CYC, 1);
          chk("release_strobe_low", STROBE, 0);
        end
        if (!DTACK_B || !BERR_B) run++;
        else run = 0;
      end else begin
        run = 0;
      end
      p_dt = DTACK_B;
      p_be = BERR_B;
      p_ds = DEV_STROBE;
    end
  end

  task automatic do_txn(input int sel, input logic [9:0] cmd, input logic wrb, input int lat,
                        input int extra, input bit force_rd, input logic [15:0] rd_val,
                        input logic [15:0] wdata);
    exp_t e;
    bit   got;
    for (int i = 0; i < NDEV; i++) DEV_RDATA[16*i +: 16] = 16'($urandom);
    if (force_rd && sel < NDEV) DEV_RDATA[16*sel +: 16] = rd_val;
    e.cmd = cmd;
    e.wrb = wrb;
    e.dev = '0;
    if (sel >= NDEV || lat > TMO_CYC) begin
      e.berr = 1;
      m_err  = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
      e.lat  = (sel >= NDEV) ? -1 : TMO_CYC + 1;
    end else begin
      e.berr = 0;
      e.dev[sel] = 1'b1;
      if (wrb) m_out = DEV_RDATA[16*sel +: 16];
      e.lat = lat + 1;
    end
    e.out = m_out;
    e.err = m_err;
    exp_q.push_back(e);

    cur_sel = sel;
    cur_lat = lat;
    DEV_SEL = 4'(sel);
    CMD_IN  = cmd;
    WRITE_B = wrb;
    INDATA  = wdata;
    STROBE  = 1'b1;
    got = 0;
    for (int k = 1; k <= TMO_CYC + 40; k++) begin
      @(negedge FASTCLK);
      if (k == 4) begin
        DEV_SEL = 4'($urandom);
        CMD_IN  = 10'($urandom);
        WRITE_B = 1'($urandom);
      end
      if (!DTACK_B || !BERR_B) begin got = 1; break; end
    end
    chk("resp_in_time", got, 1);
    repeat (extra) @(negedge FASTCLK);
    STROBE = 1'b0;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge FASTCLK);
      if (DTACK_B && BERR_B && !DEV_STROBE) begin got = 1; break; end
    end
    chk("release_in_time", got, 1);
    repeat (2) @(negedge FASTCLK);
  endtask

  task automatic chk_reset_vals();
    chk("rst_device", DEVICE, 0);
    chk("rst_command", COMMAND, 0);
    chk("rst_dev_write_b", DEV_WRITE_B, 1);
    chk("rst_dev_strobe", DEV_STROBE, 0);
    chk("rst_outdata", OUTDATA, 0);
    chk("rst_dtack_b", DTACK_B, 1);
    chk("rst_berr_b", BERR_B, 1);
    chk("rst_err_cnt", ERR_CNT, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got, bad;
    repeat (3) @(negedge FASTCLK);
    chk_reset_vals();
    RST = 1'b0;
    mon_en = 1;
    repeat (4) @(negedge FASTCLK);

    do_txn(0, 10'h000, 1'b1, 4, 2, 1, 16'h7E19, 16'h0000);   // read, device 0
    do_txn(3, 10'h2A5, 1'b0, 3, 1, 0, 16'h0000, 16'hBEEF);   // write, device 3
    do_txn(9, 10'h155, 1'b1, 0, 0, 0, 16'h0000, 16'h1234);   // unmapped
    do_txn(2, 10'h0F0, 1'b1, NEVER, 0, 0, 16'h0000, 16'h0);  // timeout
    do_txn(5, 10'h3C3, 1'b1, TMO_CYC, 1, 0, 16'h0000, 16'h0); // ack/timeout tie, early drop

    for (int t = 0; t < 40; t++) begin
      int sel, lat;
      sel = $urandom_range(0, 15);
      lat = ($urandom_range(0, 9) == 0) ? TMO_CYC + 1 + $urandom_range(0, 40)
                                        : $urandom_range(0, 12);
      do_txn(sel, 10'($urandom), 1'($urandom), lat, $urandom_range(0, 3), 0, 16'h0,
             16'($urandom));
    end

    // Reset in the middle of an access with the strobe held high.
    cur_sel = 1;
    cur_lat = NEVER;
    DEV_SEL = 4'd1;
    WRITE_B = 1'b1;
    STROBE  = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge FASTCLK);
      if (DEV_STROBE) begin got = 1; break; end
    end
    chk("rst_access_reached", got, 1);
    repeat (5) @(negedge FASTCLK);
    RST = 1'b1;
    @(negedge FASTCLK);
    chk_reset_vals();
    RST = 1'b0;
    m_out = '0;
    m_err = '0;
    bad = 0;
    repeat (20) begin
      @(negedge FASTCLK);
      if (DEVICE != '0 || DEV_STROBE || !DTACK_B || !BERR_B) bad = 1;
    end
    chk("rst_no_retrigger", bad, 0);
    STROBE = 1'b0;
    repeat (4) @(negedge FASTCLK);
    do_txn(6, 10'h11F, 1'b1, 1, 0, 1, 16'hA55A, 16'h0);

    // Drive the error counter into saturation.
    for (int t = 0; t < 260; t++)
      do_txn(8 + (t % 8), 10'($urandom), 1'($urandom), 0, 0, 0, 16'h0, 16'h0);
    chk("sb_drained", exp_q.size(), 0);
    chk("err_cnt_saturated", ERR_CNT, m_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
